// File: rtl/sub_serial_pkg.sv
// ============================================================================
// sub_serial_pkg : shared types and helpers for the bit-serial subtractor
// Revision       : 1.0
// ============================================================================
`default_nettype none

package sub_serial_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit-counter width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sub_full.sv
// ============================================================================
// sub_full : combinational full subtractor cell, d = x - y - z, borrow bo
// Revision : 1.0
// ============================================================================
`default_nettype none

module sub_full (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ z;
    assign bo = (~x & y) | (~(x ^ y) & z);

endmodule

`default_nettype wire

// File: rtl/sub_serial.sv
// ============================================================================
// sub_serial : LSB-first bit-serial subtractor, diff = a - b - b_in
//              Optional signed-overflow output enabled by SUB_SERIAL_OVF_EN.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module sub_serial
    import sub_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
`ifdef SUB_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int                 c_cnt_w = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_br;
    logic [WIDTH-1:0]   r_diff_sr;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_d;
    logic               w_bo;
    logic [WIDTH-1:0]   w_sr_next;

    sub_full u_sub_full (
        .x  (r_a[0]),
        .y  (r_b[0]),
        .z  (r_br),
        .d  (w_d),
        .bo (w_bo)
    );

    assign w_sr_next = {w_d, r_diff_sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_br      <= 1'b0;
            r_diff_sr <= '0;
            r_cnt     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            diff      <= '0;
            b_out     <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_br      <= b_in;
                        r_cnt     <= '0;
                        r_diff_sr <= '0;
                        busy      <= 1'b1;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_br      <= w_bo;
                    r_diff_sr <= w_sr_next;
                    r_a       <= r_a >> 1;
                    r_b       <= r_b >> 1;
                    r_cnt     <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        diff    <= w_sr_next;
                        b_out   <= w_bo;
`ifdef SUB_SERIAL_OVF_EN
                        // Borrow into the MSB differs from borrow out of it.
                        ovf     <= r_br ^ w_bo;
`endif
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sub_serial.sv
// ============================================================================
// tb_sub_serial : directed scoreboard bench for sub_serial (WIDTH = 4)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_sub_serial;

    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             b_out;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             b_out;
`ifdef SUB_SERIAL_OVF_EN
    logic             ovf;
`endif

    exp_t exp_q[$];
    int   done_cycles[$];
    int   n_cmp;
    int   n_err;
    int   done_cnt;
    int   busy_cycles;
    int   cyc;

    sub_serial #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .b_out (b_out)
`ifdef SUB_SERIAL_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (busy === 1'b1) busy_cycles++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cycles.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("diff", int'(diff), int'(e.diff));
                check("b_out", int'(b_out), int'(e.b_out));
`ifdef SUB_SERIAL_OVF_EN
                check("ovf", int'(ovf), int'(e.ovf));
`endif
            end
        end
    end

    task automatic push_exp(input int d, input int bo, input int ov);
        exp_t e;
        e.diff  = WIDTH'(d);
        e.b_out = bo[0];
        e.ovf   = ov[0];
        exp_q.push_back(e);
    endtask

    task automatic start_op(input int av, input int bv, input int bi);
        @(negedge clk);
        a     = WIDTH'(av);
        b     = WIDTH'(bv);
        b_in  = bi[0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_dones(input int target, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < 40) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (done_cnt < target) check({name, "_timeout"}, done_cnt, target);
    endtask

    task automatic run_op(input int av, input int bv, input int bi,
                          input int d, input int bo, input int ov, input string name);
        int base;
        base = done_cnt;
        push_exp(d, bo, ov);
        start_op(av, bv, bi);
        wait_dones(base + 1, name);
    endtask

    initial begin
        int base;
        n_cmp = 0; n_err = 0; done_cnt = 0; busy_cycles = 0; cyc = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_diff", int'(diff), 0);
        check("rst_b_out", int'(b_out), 0);

        // 7 - 3: busy exactly WIDTH cycles
        busy_cycles = 0;
        run_op(7, 3, 0, 4, 0, 0, "op_7_3");
        check("busy_cycles", busy_cycles, WIDTH);
        @(negedge clk);
        check("done_single_cycle", int'(done), 0);
        check("diff_held", int'(diff), 4);

        run_op(3, 7, 0, 12, 1, 0, "op_3_7");
        run_op(0, 0, 1, 15, 1, 0, "op_0_0_1");
        run_op(8, 1, 0, 7, 0, 1, "op_8_1");

        // Second start while shifting must be ignored
        base = done_cnt;
        push_exp(7, 0, 1);
        start_op(9, 2, 0);
        start_op(1, 1, 0);
        wait_dones(base + 1, "op_9_2");
        repeat (10) @(negedge clk);
        check("ignored_start_dones", done_cnt - base, 1);

        // Reset on the second busy cycle aborts without a done pulse
        base = done_cnt;
        start_op(5, 1, 0);
        @(negedge clk);
        check("abort_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_diff", int'(diff), 0);
        check("abort_b_out", int'(b_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_no_done", done_cnt - base, 0);
        run_op(5, 1, 0, 4, 0, 0, "op_5_1");

        // Start held high: one result every WIDTH+2 cycles
        base = done_cnt;
        repeat (3) push_exp(6, 0, 1);
        @(negedge clk);
        a = 4'd10; b = 4'd4; b_in = 1'b0; start = 1'b1;
        wait_dones(base + 3, "held_start");
        start = 1'b0;
        if (done_cycles.size() >= 3) begin
            check("interval_1", done_cycles[$-1] - done_cycles[$-2], WIDTH + 2);
            check("interval_2", done_cycles[$] - done_cycles[$-1], WIDTH + 2);
        end
        repeat (12) @(negedge clk);
        check("held_done_count", done_cnt - base, 3);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sub_serial.md
Name: sub_serial

Overview:
- Bit-serial, LSB-first subtractor with a start/busy/done handshake. Computes diff = a - b - b_in and a borrow-out.
- Processes one bit per clock through a single full-subtractor cell and a registered borrow. Ripple-carry adders occupy the add direction; this block is the area-minimal subtract direction.
- Sits in the datapath next to the adder blocks and serves multi-cycle arithmetic where latency is acceptable and area is not.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request pulse; sampled only in IDLE
- a  input  WIDTH  minuend; captured when start is accepted
- b  input  WIDTH  subtrahend; captured when start is accepted
- b_in  input  1  borrow-in; captured when start is accepted
- busy  output  1  high while a subtraction is in progress
- done  output  1  single-cycle pulse; result valid
- diff  output  WIDTH  result; held until the next accepted start
- b_out  output  1  final borrow; held with diff

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low; all state clears immediately on assertion, with no clock required.
- Reset values: busy=0, done=0, diff=0, b_out=0, FSM=IDLE, bit counter=0, internal shift registers=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT on the edge where start=1:
  - latch a into shift reg A, b into shift reg B, b_in into borrow reg BR;
  - clear counter and the diff shift reg;
  - busy=1 from the next cycle.
- SHIFT, one edge per bit, with x=A[0], y=B[0], z=BR:
  - d = x^y^z
  - BR <= (~x & y) | (~(x^y) & z)
  - diff shift reg <= {d, diff_sr[WIDTH-1:1]}
  - A and B shift right by 1; counter increments.
- SHIFT -> DONE on the edge that processes bit WIDTH-1 (counter == WIDTH-1). On that edge:
  - diff <= final shifted value;
  - b_out <= new BR;
  - busy <= 0, done <= 1.
- DONE -> IDLE on the next edge, unconditionally; done <= 0.
- Latency: start sampled at edge k; done high in the cycle after edge k+WIDTH. Exactly WIDTH busy cycles.
- Throughput: one operation per WIDTH+2 cycles; start may be held high continuously.
- start is ignored in SHIFT and DONE. No queuing; the in-flight result is unaffected.
- Operands are sampled only at acceptance; a, b and b_in may change freely afterwards.
- Arithmetic is modulo 2^WIDTH. b_out=1 iff a < b + b_in (unsigned). Example: a=0, b=0, b_in=1 gives diff all-ones, b_out=1.
- Reset during SHIFT or DONE:
  - aborts the operation and clears diff/b_out;
  - no done pulse is produced;
  - after deassertion the FSM is in IDLE and the next start is accepted normally.
- Counter width: $clog2(WIDTH). No wrap-around use beyond WIDTH-1.

Optional Feature:
- Macro: SUB_SERIAL_OVF_EN.
- When defined, adds output port ovf (1 bit):
  - two's-complement signed overflow of a - b - b_in;
  - computed as BR_into_msb XOR BR_out_of_msb and registered on the same edge as diff;
  - reset value 0; held with diff; cleared by reset.
- When undefined, the port and its logic are absent and the rest of the behaviour is identical.

Decomposition:
- Package sub_serial_pkg:
  - state enum type (IDLE, SHIFT, DONE);
  - localparam DEFAULT_WIDTH = 4;
  - counter-width helper function.
- Sub-module sub_full: combinational full subtractor (outputs d and bo; inputs x, y, z). It is the bit-serial counterpart of the existing full-adder cell.
- All sequencing logic lives in sub_serial itself.

Test Plan (WIDTH=4):
- a=7, b=3, b_in=0, pulse start -> busy high 4 cycles, then done 1 cycle; diff=4, b_out=0.
- a=3, b=7, b_in=0 -> diff=12, b_out=1; with SUB_SERIAL_OVF_EN, ovf=0.
- a=0, b=0, b_in=1 -> diff=15, b_out=1. Separately a=8, b=1 with SUB_SERIAL_OVF_EN -> diff=7, ovf=1.
- Start a=9, b=2; pulse start again mid-SHIFT with a=1, b=1 -> second start ignored; diff=7, exactly one done pulse.
- Start a=5, b=1; assert rst_n low for 1 cycle on the 2nd busy cycle -> busy, done, diff, b_out all 0 immediately with no done pulse. Then a=5, b=1 -> diff=4.
- start held high continuously with a=10, b=4 -> done pulses every 6 cycles, each with diff=6, b_out=0.
